// File: rtl/sipo_capture_24bit.sv
// Serial-in/parallel-out capture: rebuilds LSB-first words from a serial stream and
// holds each finished word in a one-entry valid/ready buffer with a sticky overrun flag.
module sipo_capture_24bit #(
  parameter int size  = 24,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_shift_en,
  input  logic             i_data_in,
  input  logic             i_flush,
  output logic [size:1]    o_data_out,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_overrun,
  input  logic             i_overrun_clr,
  output logic [CNT_W-1:0] o_bit_cnt
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [size:1]    r_shift_reg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [size:1]    r_data_out;
  logic             r_out_valid;
  logic             r_overrun;

  logic [size:1]    w_word;
  logic             w_last;
  logic             w_push;
  logic             w_pop;

  // New bit enters at the top, so after a full word the first bit lands in bit 1.
  assign w_word = {i_data_in, r_shift_reg[size:2]};
  assign w_last = (r_bit_cnt == CNT_W'(size - 1));
  assign w_push = i_shift_en && !i_flush && (r_state == SHIFT) && w_last;
  assign w_pop  = r_out_valid && i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state     <= IDLE;
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (i_flush) begin
        r_state     <= IDLE;
        r_bit_cnt   <= '0;
        r_shift_reg <= '0;
      end else if (i_shift_en) begin
        r_shift_reg <= w_word;
        case (r_state)
          IDLE: begin
            r_state   <= SHIFT;
            r_bit_cnt <= CNT_W'(1);
          end
          SHIFT: begin
            if (w_last) begin
              r_state   <= IDLE;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
          end
        endcase
      end

      // Clear first so a drop in the same cycle still leaves the flag set.
      if (i_overrun_clr) begin
        r_overrun <= 1'b0;
      end

      if (w_push && (!r_out_valid || w_pop)) begin
        r_data_out  <= w_word;
        r_out_valid <= 1'b1;
      end else if (w_push) begin
        r_overrun <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_data_out  = r_data_out;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = r_overrun;
  assign o_bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_sipo_capture_24bit.sv
// Directed bench for sipo_capture_24bit: each task drives one scenario and checks
// the outputs against hand-computed values.
module tb_sipo_capture_24bit;

  logic        clk;
  logic        clr;
  logic        shift_en;
  logic        data_in;
  logic        flush;
  logic [24:1] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        overrun_clr;
  logic [4:0]  bit_cnt;

  int errors = 0;
  int checks = 0;

  sipo_capture_24bit #(.size(24), .CNT_W(5)) dut (
    .i_clk         (clk),
    .i_clr         (clr),
    .i_shift_en    (shift_en),
    .i_data_in     (data_in),
    .i_flush       (flush),
    .o_data_out    (data_out),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_overrun     (overrun),
    .i_overrun_clr (overrun_clr),
    .o_bit_cnt     (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive_bit(input logic b);
    @(negedge clk);
    shift_en = 1'b1;
    data_in  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) drive_bit(w[i]);
  endtask

  task automatic go_idle(input int cycles);
    @(negedge clk);
    shift_en = 1'b0;
    data_in  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 24'h0) begin
      errors++; $display("FAIL reset_data: got %h expected %h", data_out, 24'h0);
    end
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got valid=%b ovr=%b expected 0 0", out_valid, overrun);
    end
    checks++;
    if (bit_cnt !== 5'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", bit_cnt);
    end
  endtask

  task automatic test_single_word;
    out_ready = 1'b0;
    send_bits(24'hA5C3F0, 0, 0);
    checks++;
    if (bit_cnt !== 5'd1) begin
      errors++; $display("FAIL cnt_first: got %0d expected 1", bit_cnt);
    end
    send_bits(24'hA5C3F0, 1, 11);
    go_idle(3);
    checks++;
    if (bit_cnt !== 5'd12 || out_valid !== 1'b0) begin
      errors++; $display("FAIL gap_hold: got cnt=%0d valid=%b expected 12 0", bit_cnt, out_valid);
    end
    send_bits(24'hA5C3F0, 12, 22);
    checks++;
    if (bit_cnt !== 5'd23 || out_valid !== 1'b0 || data_out !== 24'h0) begin
      errors++; $display("FAIL pre_last: got cnt=%0d valid=%b data=%h expected 23 0 000000", bit_cnt, out_valid, data_out);
    end
    send_bits(24'hA5C3F0, 23, 23);
    checks++;
    if (data_out !== 24'hA5C3F0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL word1: got data=%h valid=%b expected a5c3f0 1", data_out, out_valid);
    end
    checks++;
    if (bit_cnt !== 5'd0 || overrun !== 1'b0) begin
      errors++; $display("FAIL word1_cnt_ovr: got cnt=%0d ovr=%b expected 0 0", bit_cnt, overrun);
    end
    go_idle(2);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 24'hA5C3F0) begin
      errors++; $display("FAIL word1_hold: got data=%h valid=%b expected a5c3f0 1", data_out, out_valid);
    end
  endtask

  task automatic test_overrun;
    send_bits(24'h123456, 0, 23);
    checks++;
    if (overrun !== 1'b1 || data_out !== 24'hA5C3F0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got ovr=%b data=%h valid=%b expected 1 a5c3f0 1", overrun, data_out, out_valid);
    end
    go_idle(1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clr: got %b expected 0", overrun);
    end
    @(negedge clk);
    overrun_clr = 1'b0;
    send_bits(24'h654321, 0, 22);
    @(negedge clk);
    overrun_clr = 1'b1;
    shift_en    = 1'b1;
    data_in     = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b1 || data_out !== 24'hA5C3F0) begin
      errors++; $display("FAIL set_wins: got ovr=%b data=%h expected 1 a5c3f0", overrun, data_out);
    end
    @(negedge clk);
    shift_en  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b0 || out_valid !== 1'b0 || data_out !== 24'hA5C3F0) begin
      errors++; $display("FAIL pop_clear: got ovr=%b valid=%b data=%h expected 0 0 a5c3f0", overrun, out_valid, data_out);
    end
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    send_bits(24'hFFFFFF, 0, 23);
    checks++;
    if (data_out !== 24'hFFFFFF || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_word1: got data=%h valid=%b expected ffffff 1", data_out, out_valid);
    end
    send_bits(24'h000001, 0, 0);
    checks++;
    if (out_valid !== 1'b0 || data_out !== 24'hFFFFFF) begin
      errors++; $display("FAIL b2b_pop: got data=%h valid=%b expected ffffff 0", data_out, out_valid);
    end
    send_bits(24'h000001, 1, 22);
    checks++;
    if (out_valid !== 1'b0 || data_out !== 24'hFFFFFF || bit_cnt !== 5'd23) begin
      errors++; $display("FAIL b2b_partial: got data=%h valid=%b cnt=%0d expected ffffff 0 23", data_out, out_valid, bit_cnt);
    end
    send_bits(24'h000001, 23, 23);
    checks++;
    if (data_out !== 24'h000001 || out_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_word2: got data=%h valid=%b ovr=%b expected 000001 1 0", data_out, out_valid, overrun);
    end
    go_idle(1);
    checks++;
    if (out_valid !== 1'b0 || data_out !== 24'h000001) begin
      errors++; $display("FAIL b2b_drain: got data=%h valid=%b expected 000001 0", data_out, out_valid);
    end
  endtask

  task automatic test_flush;
    send_bits(24'hFFFFFF, 0, 9);
    checks++;
    if (bit_cnt !== 5'd10) begin
      errors++; $display("FAIL flush_pre: got %0d expected 10", bit_cnt);
    end
    @(negedge clk);
    flush    = 1'b1;
    shift_en = 1'b1;
    data_in  = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bit_cnt !== 5'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_cnt: got cnt=%0d valid=%b expected 0 0", bit_cnt, out_valid);
    end
    @(negedge clk);
    flush    = 1'b0;
    shift_en = 1'b0;
    send_bits(24'h00F00F, 0, 23);
    checks++;
    if (data_out !== 24'h00F00F || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_word: got data=%h valid=%b expected 00f00f 1", data_out, out_valid);
    end
    send_bits(24'hABCABC, 0, 11);
    checks++;
    if (bit_cnt !== 5'd12) begin
      errors++; $display("FAIL clr_pre: got %0d expected 12", bit_cnt);
    end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bit_cnt !== 5'd0 || out_valid !== 1'b0 || data_out !== 24'h0) begin
      errors++; $display("FAIL clr_mid: got cnt=%0d valid=%b data=%h expected 0 0 000000", bit_cnt, out_valid, data_out);
    end
    @(negedge clk);
    clr      = 1'b0;
    shift_en = 1'b0;
  endtask

  task automatic test_pop_push;
    out_ready = 1'b0;
    send_bits(24'h3C3C3C, 0, 23);
    checks++;
    if (data_out !== 24'h3C3C3C || out_valid !== 1'b1) begin
      errors++; $display("FAIL pp_first: got data=%h valid=%b expected 3c3c3c 1", data_out, out_valid);
    end
    send_bits(24'hC0FFEE, 0, 22);
    @(negedge clk);
    out_ready = 1'b1;
    data_in   = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_out !== 24'hC0FFEE || out_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL pp_same_cycle: got data=%h valid=%b ovr=%b expected c0ffee 1 0", data_out, out_valid, overrun);
    end
    go_idle(1);
    checks++;
    if (out_valid !== 1'b0 || data_out !== 24'hC0FFEE) begin
      errors++; $display("FAIL pp_drain: got data=%h valid=%b expected c0ffee 0", data_out, out_valid);
    end
  endtask

  initial begin
    clr         = 1'b0;
    shift_en    = 1'b0;
    data_in     = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    test_reset;
    test_single_word;
    test_overrun;
    test_back_to_back;
    test_flush;
    test_pop_push;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
